// File: rtl/ahb_slv_mem.sv
// ahb_slv_mem: AHB-Lite responder backed by a word-organised internal SRAM.
// Handles byte/halfword/word accesses, a fixed number of wait states per data
// phase, and a two-cycle ERROR response for out-of-range or misaligned accesses.
// Optional build macro AHB_SLV_LFSR_WAIT_EN: when defined, each transfer's wait
// count (0..3) comes from an 8-bit LFSR and WAIT_STATES is ignored.
//
// state  | meaning
// IDLE   | no data phase in progress, ready, OKAY
// WAIT   | data phase stalled, wait counter running
// DATA   | final data-phase cycle, write commits / read data presented
// ERR1   | first ERROR cycle (hreadyout low)
// ERR2   | second ERROR cycle (hreadyout high)
module ahb_slv_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hrst,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [1:0]            htrans,
    input  logic                  hready,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hreadyout,
    output logic                  hresp
);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int WIDX_W = ADDR_WIDTH - 2;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t                state;
    state_t                state_nxt;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [IDX_W-1:0]      idx_q;
    logic [1:0]            lo_q;
    logic [1:0]            size_q;
    logic                  write_q;
    logic                  err_q;
    logic [3:0]            wait_cnt;

    logic                  sample;
    logic                  take;
    logic                  new_err;
    logic [3:0]            wait_len;
    logic [IDX_W-1:0]      new_idx;
    logic                  commit;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wr_word;
    logic                  rd_nxt;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    // Burst type and the BUSY/IDLE distinction carry no information for this slave.
    logic                  unused_ok;
    assign unused_ok = ^{hburst, htrans[0]};

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lo);
        logic [3:0] m;
        case (sz)
            2'd0:    m = 4'b0001 << lo;
            2'd1:    m = lo[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    assign sample  = hsel & hready & htrans[1];
    assign take    = sample & ((state == S_IDLE) | (state == S_DATA) | (state == S_ERR2));
    assign new_idx = haddr[IDX_W+1:2];
    assign commit  = (state == S_DATA) & write_q & ~err_q;
    assign be_q    = lane_mask(size_q, lo_q);

`ifdef AHB_SLV_LFSR_WAIT_EN
    logic [7:0] lfsr;

    // Free-running Fibonacci LFSR (taps 8,6,5,4) supplying pseudo-random wait counts.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign wait_len = {2'b00, lfsr[1:0]};
`else
    assign wait_len = 4'(WAIT_STATES);
`endif

    // Classify the transfer on the bus: out of range, illegal size or misaligned.
    always_comb begin
        new_err = 1'b0;
        if (haddr[ADDR_WIDTH-1:2] >= WIDX_W'(MEM_DEPTH)) new_err = 1'b1;
        if (hsize > 3'd2)                                 new_err = 1'b1;
        if ((hsize == 3'd1) && haddr[0])                  new_err = 1'b1;
        if ((hsize == 3'd2) && (haddr[1:0] != 2'b00))     new_err = 1'b1;
    end

    // Merge the write lanes into the currently stored word.
    always_comb begin
        wr_word = mem[idx_q];
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) wr_word[8*i +: 8] = hwdata[8*i +: 8];
        end
    end

    // Next-state decision; IDLE, DATA and ERR2 all accept a new transfer the same way.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (!take)                 state_nxt = S_IDLE;
                else if (new_err)          state_nxt = S_ERR1;
                else if (wait_len != 4'd0) state_nxt = S_WAIT;
                else                       state_nxt = S_DATA;
            end
            S_WAIT:  if (wait_cnt == 4'd0) state_nxt = S_DATA;
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read data for the coming DATA cycle; a write committing at this same edge
    // to the same word is forwarded so read-after-write returns the new data.
    always_comb begin
        rd_nxt = 1'b0;
        rd_idx = idx_q;
        if (state_nxt == S_DATA) begin
            if (state == S_WAIT) begin
                rd_nxt = ~write_q;
            end else begin
                rd_nxt = ~hwrite;
                rd_idx = new_idx;
            end
        end
        rd_word = (commit && (rd_idx == idx_q)) ? wr_word : mem[rd_idx];
    end

    // FSM, address-phase capture, wait counter and registered bus outputs.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
            wait_cnt  <= 4'd0;
            idx_q     <= '0;
            lo_q      <= 2'b00;
            size_q    <= 2'b00;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            hreadyout <= ~((state_nxt == S_WAIT) || (state_nxt == S_ERR1));
            hresp     <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
            hrdata    <= rd_nxt ? rd_word : '0;
            if (take) begin
                idx_q    <= new_idx;
                lo_q     <= haddr[1:0];
                size_q   <= hsize[1:0];
                write_q  <= hwrite;
                err_q    <= new_err;
                wait_cnt <= wait_len - 4'd1;
            end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // SRAM write port; contents survive reset but a write caught by reset is dropped.
    always_ff @(posedge hclk) begin
        if (!hrst && commit) begin
            mem[idx_q] <= wr_word;
        end
    end

endmodule

// File: tb/tb_ahb_slv_mem.sv
// Bench for ahb_slv_mem: two instances (zero and three wait states) driven by
// a pipelined AHB master; expected responses come from a byte-addressed model.
module tb_ahb_slv_mem;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int NI    = 2;
    localparam int WS0   = 0;
    localparam int WS1   = 3;

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] data;
        int          waits;
    } exp_t;

    logic          hclk = 1'b0;
    logic [NI-1:0] hrst;
    logic [NI-1:0] hsel;
    logic [NI-1:0] hwrite;
    logic [NI-1:0] hreadyout;
    logic [NI-1:0] hresp;
    logic [31:0]   haddr  [NI];
    logic [31:0]   hwdata [NI];
    logic [31:0]   hrdata [NI];
    logic [2:0]    hsize  [NI];
    logic [2:0]    hburst [NI];
    logic [1:0]    htrans [NI];

    logic [7:0]    rb [NI][256];
    exp_t          expq [$];
    logic [31:0]   dph_wdata;
    int            cur_g;
    bit            mon_en;
    bit            pend;
    int            wcnt;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ahb_slv_mem #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .MEM_DEPTH  (DEPTH),
            .WAIT_STATES((g == 0) ? WS0 : WS1)
        ) u_dut (
            .hclk     (hclk),
            .hrst     (hrst[g]),
            .hsel     (hsel[g]),
            .haddr    (haddr[g]),
            .hwrite   (hwrite[g]),
            .hsize    (hsize[g]),
            .hburst   (hburst[g]),
            .htrans   (htrans[g]),
            .hready   (hreadyout[g]),
            .hwdata   (hwdata[g]),
            .hrdata   (hrdata[g]),
            .hreadyout(hreadyout[g]),
            .hresp    (hresp[g])
        );
    end

    always #5 hclk = ~hclk;

    always @(posedge hclk) cyc <= cyc + 1;

    function automatic int ws_of(input int g);
        return (g == 0) ? WS0 : WS1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s g=%0d act=%h req=%h t=%0t", name, cur_g, act, req, $time);
        end
    endtask

    task automatic wait_accept(input int g);
        int n = 0;
        @(negedge hclk);
        while (!hreadyout[g] && n < 40) begin
            n++;
            @(negedge hclk);
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout g=%0d act=hreadyout_stuck_low req=hreadyout_high", g);
        end
        @(posedge hclk);
        #1;
    endtask

    // Address phase for one transfer; the model is updated in program order.
    task automatic issue(input int g, input logic [31:0] a, input logic w, input logic [2:0] sz,
                         input logic [31:0] val, input logic [1:0] tr, input logic [2:0] bu);
        exp_t e;
        int   nb;
        int   wa;
        nb      = (sz <= 3'd2) ? (1 << sz) : 1;
        e.err   = (sz > 3'd2) || ((a % nb) != 0) || ((a / 4) >= DEPTH);
        e.rd    = !w;
        e.waits = e.err ? 1 : ws_of(g);
        e.data  = '0;
        if (!e.err) begin
            wa = int'(a) & 'hFC;
            if (w) begin
                for (int i = 0; i < nb; i++) rb[g][int'(a) + i] = val[8*i +: 8];
            end else begin
                e.data = {rb[g][wa+3], rb[g][wa+2], rb[g][wa+1], rb[g][wa]};
            end
        end
        expq.push_back(e);
        hwdata[g] = dph_wdata;
        hsel[g]   = 1'b1;
        haddr[g]  = a;
        hwrite[g] = w;
        hsize[g]  = sz;
        htrans[g] = tr;
        hburst[g] = bu;
        wait_accept(g);
        dph_wdata = w ? (val << (8 * (a % 4))) : $urandom;
    endtask

    // kind 0: IDLE, 1: NONSEQ with hsel low, 2: BUSY
    task automatic idle(input int g, input int kind);
        hwdata[g] = dph_wdata;
        hsel[g]   = (kind != 1);
        htrans[g] = (kind == 2) ? 2'b01 : ((kind == 1) ? 2'b10 : 2'b00);
        haddr[g]  = $urandom;
        hwrite[g] = 1'($urandom_range(0, 1));
        hsize[g]  = 3'd2;
        hburst[g] = 3'd0;
        wait_accept(g);
        dph_wdata = $urandom;
    endtask

    // Monitor: pops an expectation at each completed data phase.
    initial begin
        exp_t e;
        int   g;
        forever begin
            @(negedge hclk);
            if (mon_en) begin
                g = cur_g;
                if (pend) begin
                    if (!hreadyout[g]) begin
                        wcnt++;
                        if (expq.size() > 0) chk("wait_hresp", 32'(hresp[g]), 32'(expq[0].err));
                        chk("wait_hrdata", hrdata[g], 32'h0);
                    end else if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_response g=%0d act=completion req=none", g);
                    end else begin
                        e = expq.pop_front();
                        chk("hresp", 32'(hresp[g]), 32'(e.err));
                        chk("hrdata", hrdata[g], (e.rd && !e.err) ? e.data : 32'h0);
`ifndef AHB_SLV_LFSR_WAIT_EN
                        chk("wait_cycles", 32'(wcnt), 32'(e.waits));
`endif
                        wcnt = 0;
                    end
                end else begin
                    chk("idle_hreadyout", 32'(hreadyout[g]), 32'h1);
                    chk("idle_hresp", 32'(hresp[g]), 32'h0);
                    chk("idle_hrdata", hrdata[g], 32'h0);
                end
                if (hreadyout[g]) pend = hsel[g] && htrans[g][1];
            end
        end
    end

    task automatic run_suite(input int g);
        int          c0;
        int          r;
        logic [31:0] a;
        logic [2:0]  sz;
        cur_g   = g;
        hrst[g] = 1'b1;
        repeat (3) @(posedge hclk);
        #1;
        hrst[g] = 1'b0;
        chk("rst_hreadyout", 32'(hreadyout[g]), 32'h1);
        chk("rst_hresp", 32'(hresp[g]), 32'h0);
        chk("rst_hrdata", hrdata[g], 32'h0);
        pend   = 1'b0;
        wcnt   = 0;
        mon_en = 1'b1;

        for (int w = 0; w < 64; w++) issue(g, 32'(w * 4), 1'b1, 3'd2, $urandom, 2'b10, 3'd0);

        issue(g, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 2'b10, 3'd0);
        issue(g, 32'h10, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);

        issue(g, 32'h20, 1'b1, 3'd2, 32'h0, 2'b10, 3'd0);
        issue(g, 32'h21, 1'b1, 3'd0, 32'h11, 2'b10, 3'd0);
        issue(g, 32'h23, 1'b1, 3'd0, 32'h22, 2'b10, 3'd0);
        issue(g, 32'h20, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);
        issue(g, 32'h22, 1'b1, 3'd1, 32'hABCD, 2'b10, 3'd0);
        issue(g, 32'h20, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);

        issue(g, 32'h1000, 1'b1, 3'd2, 32'h12345678, 2'b10, 3'd0);
        issue(g, 32'h02, 1'b1, 3'd2, 32'hCAFEF00D, 2'b10, 3'd0);
        issue(g, 32'h01, 1'b1, 3'd1, 32'h5555, 2'b10, 3'd0);
        issue(g, 32'h04, 1'b0, 3'd3, 32'h0, 2'b10, 3'd0);
        idle(g, 0);
        issue(g, 32'h00, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);
        issue(g, 32'h04, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);
        idle(g, 0);

        c0 = cyc;
        for (int i = 0; i < 4; i++)
            issue(g, 32'(32'h40 + 4 * i), 1'b1, 3'd2, $urandom, (i == 0) ? 2'b10 : 2'b11, 3'd3);
        for (int i = 0; i < 4; i++)
            issue(g, 32'(32'h40 + 4 * i), 1'b0, 3'd2, 32'h0, (i == 0) ? 2'b10 : 2'b11, 3'd3);
        idle(g, 0);
`ifndef AHB_SLV_LFSR_WAIT_EN
        chk("burst_cycles", 32'(cyc - c0), 32'(8 * (ws_of(g) + 1) + 1));
`endif

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                idle(g, $urandom_range(0, 2));
            end else begin
                sz = 3'($urandom_range(0, 2));
                a  = 32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 32'd1);
                if (r == 1) begin
                    case ($urandom_range(0, 2))
                        0:       a = 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
                        1:       sz = 3'($urandom_range(3, 7));
                        default: begin
                            sz = 3'($urandom_range(1, 2));
                            a  = (32'($urandom_range(0, 63)) << 2) | 32'h1;
                        end
                    endcase
                end
                issue(g, a, 1'($urandom_range(0, 1)), sz, $urandom,
                      ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10, 3'($urandom_range(0, 7)));
            end
        end
        idle(g, 0);

        mon_en    = 1'b0;
        hwdata[g] = dph_wdata;
        hsel[g]   = 1'b1;
        haddr[g]  = 32'h80;
        hwrite[g] = 1'b1;
        hsize[g]  = 3'd2;
        htrans[g] = 2'b10;
        @(posedge hclk);
        #1;
        htrans[g] = 2'b00;
        hsel[g]   = 1'b0;
        hwdata[g] = 32'h0BADF00D;
        hrst[g]   = 1'b1;
        @(posedge hclk);
        #1;
        hrst[g] = 1'b0;
        chk("rst_wait_hreadyout", 32'(hreadyout[g]), 32'h1);
        chk("rst_wait_hresp", 32'(hresp[g]), 32'h0);
        chk("rst_wait_hrdata", hrdata[g], 32'h0);
        pend   = 1'b0;
        wcnt   = 0;
        mon_en = 1'b1;
        issue(g, 32'h80, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);
        idle(g, 0);
        idle(g, 0);
        mon_en = 1'b0;
        chk("queue_empty", 32'(expq.size()), 32'h0);
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            hrst[g]   = 1'b1;
            hsel[g]   = 1'b0;
            hwrite[g] = 1'b0;
            haddr[g]  = '0;
            hwdata[g] = '0;
            hsize[g]  = 3'd2;
            hburst[g] = 3'd0;
            htrans[g] = 2'b00;
        end
        mon_en    = 1'b0;
        pend      = 1'b0;
        wcnt      = 0;
        cur_g     = 0;
        dph_wdata = '0;
        run_suite(0);
        run_suite(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/ahb_slv_mem.md
Name: ahb_slv_mem

Overview:
- AHB-Lite responder with a word-organised internal SRAM.
- Forms the slave end opposite the AHB master agent in the AHB env. It is the synthesizable DUT target for master driver and monitor traffic.
- Supports configurable wait states, byte/halfword/word access and a two-cycle ERROR response.
- Bursts need no special handling: the master supplies every beat address, and the slave follows the address/data pipeline.

Parameters:
ADDR_WIDTH, 32, haddr width
DATA_WIDTH, 32, bus width; only 32 is supported
MEM_DEPTH, 1024, number of 32-bit words; word index = haddr[ADDR_WIDTH-1:2]
WAIT_STATES, 0, fixed wait cycles (hreadyout=0) inserted per NONSEQ/SEQ data phase, range 0..15

Ports:
hclk  input  1  bus clock, all logic on rising edge
hrst  input  1  synchronous, active-high reset
hsel  input  1  slave select
haddr  input  ADDR_WIDTH  transfer address
hwrite  input  1  1=write, 0=read
hsize  input  3  0=byte, 1=halfword, 2=word
hburst  input  3  burst type; sampled, no effect on response
htrans  input  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ
hready  input  1  bus-level ready (hreadyin)
hwdata  input  DATA_WIDTH  write data, valid in data phase
hrdata  output  DATA_WIDTH  read data
hreadyout  output  1  slave ready
hresp  output  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (hrst=1 at a clock edge):
  - State goes to IDLE; hreadyout=1, hresp=0, hrdata=0.
  - Any pending write is dropped.
  - Memory contents are not reset.
- Address-phase sample condition: hsel & hready & htrans[1]. The following are captured into registers:
  - addr_q, write_q, size_q
  - err_q, which is set when any of these hold:
    - word index >= MEM_DEPTH
    - hsize > 2
    - hsize=1 and haddr[0]=1
    - hsize=2 and haddr[1:0]!=0
- IDLE/BUSY, or hsel=0, with hready=1: the next data phase is zero-wait OKAY with no memory access.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=0. On a sampled transfer:
    - err_q=1 goes to ERR1.
    - WAIT_STATES>0 goes to WAIT, loading the counter with WAIT_STATES-1.
    - Otherwise goes to DATA.
  - WAIT: hreadyout=0, hresp=0. Counter decrements; at 0 goes to DATA.
  - DATA: hreadyout=1, hresp=0.
    - Write: mem word updated at this edge; only the lanes selected by size_q/addr_q[1:0] are written (little-endian).
    - Read: hrdata = mem[addr_q index], full word; otherwise hrdata=0.
    - A new transfer sampled in the same cycle is accepted (pipelined) and takes the same next-state decision as IDLE; otherwise goes to IDLE.
  - ERR1: hreadyout=0, hresp=1; always goes to ERR2. No memory access.
  - ERR2: hreadyout=1, hresp=1. A new transfer sampled here is handled as from IDLE.
- Latency:
  - A read's data phase spans WAIT_STATES+1 cycles.
  - Back-to-back zero-wait transfers sustain 1 transfer/cycle.
- Read-after-write to the same address: the read data phase returns the newly written data, because the write commits at the edge that starts the read data phase.
- A master IDLE during ERR1 is legal; ERR2 still completes.
- hrdata in WAIT, ERR1 and ERR2 is 0.

Optional Feature:
AHB_SLV_LFSR_WAIT_EN
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset) advances every hclk.
  - The wait count for each sampled transfer is LFSR[1:0] (0..3), and WAIT_STATES is ignored.
- Not defined: the fixed WAIT_STATES count applies and no LFSR logic is synthesized.

Test Plan:
- WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 -> hrdata=0xDEADBEEF in the data phase; hreadyout=1 throughout; hresp=0.
- Byte writes 0x11 @0x21, then 0x22 @0x23, over a word previously written as 0: read @0x20 -> 0x22001100; halfword write 0xABCD @0x22 -> word read = 0xABCD1100.
- WAIT_STATES=3, read: hreadyout=0 for exactly 3 cycles, then 1 with valid data; the master holds the next address; the next transfer is sampled only on the final cycle.
- Errors: write @ word index 1024 (haddr=0x1000), and word access @0x02. Each gives hreadyout=0/hresp=1, then hreadyout=1/hresp=1, and the memory is unchanged on re-read.
- Pipelined INCR4 of SEQ writes @0x40..0x4C, then a back-to-back INCR4 read: 4 writes + 4 reads complete in 9 cycles, with data matching.
- hrst=1 asserted during WAIT of a write -> next cycle hreadyout=1, hresp=0, hrdata=0; the target word is unchanged.
